// File: rtl/priority_encoder.sv
// MSB-first priority encoder: combinational index/valid of the highest set request bit,
// plus a one-cycle registered copy with synchronous active-low reset.
module priority_encoder #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = $clog2(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  en_in,
  output logic [OUT_W-1:0] en_out,
  output logic             en_valid,
  output logic [OUT_W-1:0] en_out_q,
  output logic             en_valid_q
);

  logic [OUT_W-1:0] en_out_d;
  logic             en_valid_d;

  // Ascending scan so the last (highest) set bit overwrites any lower match.
  always_comb begin
    en_out_d = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      if (en_in[i]) begin
        en_out_d = OUT_W'(i);
      end
    end
    en_valid_d = |en_in;
  end

  assign en_out   = en_out_d;
  assign en_valid = en_valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_out_q   <= '0;
      en_valid_q <= 1'b0;
    end else begin
      en_out_q   <= en_out_d;
      en_valid_q <= en_valid_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench for priority_encoder: directed IN_W=4 cases, latency/reset sequencing,
// and a randomized comparison of IN_W=5/8 builds against a floor-log2 reference model.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] en_in4;
  logic [1:0] en_out4, en_out_q4;
  logic       en_valid4, en_valid_q4;
  logic [4:0] en_in5;
  logic [2:0] en_out5, en_out_q5;
  logic       en_valid5, en_valid_q5;
  logic [7:0] en_in8;
  logic [2:0] en_out8, en_out_q8;
  logic       en_valid8, en_valid_q8;

  int errors;
  int checks;

  priority_encoder u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_in     (en_in4),
    .en_out    (en_out4),
    .en_valid  (en_valid4),
    .en_out_q  (en_out_q4),
    .en_valid_q(en_valid_q4)
  );

  priority_encoder #(.IN_W(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_in     (en_in5),
    .en_out    (en_out5),
    .en_valid  (en_valid5),
    .en_out_q  (en_out_q5),
    .en_valid_q(en_valid_q5)
  );

  priority_encoder #(.IN_W(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_in     (en_in8),
    .en_out    (en_out8),
    .en_valid  (en_valid8),
    .en_out_q  (en_out_q8),
    .en_valid_q(en_valid_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: highest set index is floor(log2(v)); zero input maps to 0.
  function automatic int ref_idx(input int unsigned v);
    int idx;
    idx = 0;
    while (v > 1) begin
      v = v >> 1;
      idx++;
    end
    return idx;
  endfunction

  function automatic int ref_vld(input int unsigned v);
    return (v != 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] dir_in  [11];
  logic [1:0] dir_out [11];
  logic       dir_vld [11];

  int unsigned r5, r8;

  initial begin
    errors = 0;
    checks = 0;
    dir_in  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                4'b1010, 4'b0011, 4'b1111, 4'b0110, 4'b0101,
                4'b0000, 4'b0001};
    dir_out = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    dir_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_n  = 1'b0;
    en_in4 = 4'b0000;
    en_in5 = 5'b0;
    en_in8 = 8'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_q", 32'(en_out_q4), 32'd0);
    check("reset_valid_q", 32'(en_valid_q4), 32'd0);

    // Reset dominates a live request; combinational path keeps tracking.
    @(negedge clk);
    en_in4 = 4'b1111;
    @(posedge clk);
    #1;
    check("reset_hold_out_q", 32'(en_out_q4), 32'd0);
    check("reset_hold_valid_q", 32'(en_valid_q4), 32'd0);
    check("reset_comb_out", 32'(en_out4), 32'd3);
    check("reset_comb_valid", 32'(en_valid4), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed combinational cases: one-hot, multi-bit, zero vs 0001.
    for (int i = 0; i < 11; i++) begin
      en_in4 = dir_in[i];
      #10;
      check($sformatf("comb_out_%b", dir_in[i]), 32'(en_out4), 32'(dir_out[i]));
      check($sformatf("comb_valid_%b", dir_in[i]), 32'(en_valid4), 32'(dir_vld[i]));
    end

    // Registered latency: value appears exactly one edge after the drive.
    @(negedge clk);
    en_in4 = 4'b0100;
    @(posedge clk);
    #1;
    check("lat_0100_out_q", 32'(en_out_q4), 32'd2);
    check("lat_0100_valid_q", 32'(en_valid_q4), 32'd1);
    @(negedge clk);
    en_in4 = 4'b1001;
    #1;
    check("lat_pre_edge_out_q", 32'(en_out_q4), 32'd2);
    @(posedge clk);
    #1;
    check("lat_1001_out_q", 32'(en_out_q4), 32'd3);
    check("lat_1001_valid_q", 32'(en_valid_q4), 32'd1);
    @(negedge clk);
    en_in4 = 4'b0000;
    @(posedge clk);
    #1;
    check("lat_0000_out_q", 32'(en_out_q4), 32'd0);
    check("lat_0000_valid_q", 32'(en_valid_q4), 32'd0);

    // Synchronous reset mid-stream.
    @(negedge clk);
    en_in4 = 4'b1000;
    @(posedge clk);
    #1;
    check("sr_load_out_q", 32'(en_out_q4), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("sr_between_out_q", 32'(en_out_q4), 32'd3);
    check("sr_between_valid_q", 32'(en_valid_q4), 32'd1);
    check("sr_between_comb", 32'(en_out4), 32'd3);
    @(posedge clk);
    #1;
    check("sr_edge_out_q", 32'(en_out_q4), 32'd0);
    check("sr_edge_valid_q", 32'(en_valid_q4), 32'd0);
    check("sr_edge_comb", 32'(en_out4), 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sr_release_hold", 32'(en_out_q4), 32'd0);
    @(posedge clk);
    #1;
    check("sr_release_out_q", 32'(en_out_q4), 32'd3);
    check("sr_release_valid_q", 32'(en_valid_q4), 32'd1);

    // Exhaustive IN_W=4 sweep, combinational and registered.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      en_in4 = 4'(v);
      @(posedge clk);
      #1;
      check($sformatf("sweep4_out_%0d", v), 32'(en_out4), 32'(ref_idx(v)));
      check($sformatf("sweep4_valid_%0d", v), 32'(en_valid4), 32'(ref_vld(v)));
      check($sformatf("sweep4_out_q_%0d", v), 32'(en_out_q4), 32'(ref_idx(v)));
      check($sformatf("sweep4_valid_q_%0d", v), 32'(en_valid_q4), 32'(ref_vld(v)));
    end

    // Wider builds.
    en_in5 = 5'b10000;
    #1;
    check("w5_10000_out", 32'(en_out5), 32'd4);
    check("w5_10000_valid", 32'(en_valid5), 32'd1);
    en_in8 = 8'b1000_0000;
    #1;
    check("w8_msb_out", 32'(en_out8), 32'd7);

    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      r5 = (n == 0) ? 0 : $urandom_range(0, 31);
      r8 = (n == 0) ? 0 : $urandom_range(0, 255);
      // Bias some draws toward sparse patterns so single high bits get exercised.
      if (n % 4 == 1) r8 = 32'd1 << $urandom_range(0, 7);
      en_in5 = 5'(r5);
      en_in8 = 8'(r8);
      @(posedge clk);
      #1;
      check($sformatf("rand5_out_%0h", r5), 32'(en_out5), 32'(ref_idx(r5)));
      check($sformatf("rand5_valid_%0h", r5), 32'(en_valid5), 32'(ref_vld(r5)));
      check($sformatf("rand5_out_q_%0h", r5), 32'(en_out_q5), 32'(ref_idx(r5)));
      check($sformatf("rand5_valid_q_%0h", r5), 32'(en_valid_q5), 32'(ref_vld(r5)));
      check($sformatf("rand8_out_%0h", r8), 32'(en_out8), 32'(ref_idx(r8)));
      check($sformatf("rand8_valid_%0h", r8), 32'(en_valid8), 32'(ref_vld(r8)));
      check($sformatf("rand8_out_q_%0h", r8), 32'(en_out_q8), 32'(ref_idx(r8)));
      check($sformatf("rand8_valid_q_%0h", r8), 32'(en_valid_q8), 32'(ref_vld(r8)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Parameterised MSB-first priority encoder. It reports the index of the highest set bit of a request vector.
- The default configuration is the 4-to-2 encoder used by the combinational datapath.
- A combinational result is provided for same-cycle consumers.
- A registered copy of the result, with a valid flag, is provided for pipelined consumers. It uses one clock and a synchronous active-low reset.

Parameters:
- IN_W, 4, number of request inputs; legal range 2..64.
- OUT_W, $clog2(IN_W), width of the encoded index; derived, not to be overridden.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en_in  input  IN_W  request vector; bit IN_W-1 has highest priority.
- en_out  output  OUT_W  combinational index of the highest set bit of en_in.
- en_valid  output  1  combinational; 1 when any bit of en_in is set.
- en_out_q  output  OUT_W  en_out registered by one clock.
- en_valid_q  output  1  en_valid registered by one clock.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Combinational path (en_out, en_valid):
  - Pure combinational function of en_in, with no dependence on clk or rst_n.
  - Outputs settle within the same evaluation as an en_in change; zero clock latency.
- en_out encoding:
  - en_out = index of the highest-numbered bit of en_in that is 1.
  - All lower-numbered set bits are ignored.
  - Default IN_W=4 truth table:
    - 1xxx -> 11
    - 01xx -> 10
    - 001x -> 01
    - 0001 -> 00
- All-zero input:
  - en_in = 0 -> en_out = 0 and en_valid = 0.
  - Consumers must qualify en_out with en_valid, because 0001 and 0000 both give en_out = 00.
- en_valid = OR-reduction of en_in.
- X/Z on en_in need not be handled. With fully 0/1 inputs, en_out must never be X.
- Registered path (en_out_q, en_valid_q):
  - On each rising clk edge with rst_n = 1: en_out_q <= en_out and en_valid_q <= en_valid.
  - Latency is exactly one cycle from en_in to en_out_q and en_valid_q.
  - The registers update every cycle; there is no enable and no handshake.
- Reset:
  - On a rising clk edge with rst_n = 0: en_out_q <= 0 and en_valid_q <= 0.
  - Reset has no effect between edges (synchronous).
  - The combinational outputs are unaffected by reset and keep tracking en_in during reset.
  - Reset asserted mid-stream: the registered outputs go to 0 at the first edge that samples rst_n = 0.
  - On the first edge after rst_n returns to 1, the registered outputs capture the then-current en_in result.
- Width rules:
  - OUT_W = $clog2(IN_W). The index is zero-extended when IN_W is not a power of two.
  - Indices above IN_W-1 are never produced.
- The implementation must be generic in IN_W, using a loop or generate structure. A hard-coded 4-input case is not acceptable.
- Must be synthesisable with no latches. Every output is assigned on every path.

Test Plan:
1. One-hot inputs, IN_W=4, combinational, checked 10 time units after each drive:
   - 1000 -> 11
   - 0100 -> 10
   - 0010 -> 01
   - 0001 -> 00
   - en_valid = 1 for all four.
2. Multiple bits set, highest bit wins:
   - 1010 -> 11
   - 0011 -> 01
   - 1111 -> 11
   - 0110 -> 10
   - 0101 -> 10
   - en_valid = 1 for all.
3. All-zero input:
   - en_in = 0000 -> en_out = 00 and en_valid = 0.
   - Then en_in = 0001 -> en_out = 00 and en_valid = 1, which distinguishes the two cases.
4. Registered latency: hold rst_n = 1 and drive 0100, 1001, 0000 on successive cycles.
   - en_out_q/en_valid_q show 10/1, then 11/1, then 00/0, each one edge after the corresponding drive.
5. Synchronous reset with en_in = 1000:
   - Assert rst_n = 0 between edges: en_out_q is unchanged until the next rising edge, then becomes 00 with en_valid_q = 0.
   - en_out stays 11 throughout.
   - Deassert rst_n: the next edge loads en_out_q = 11 and en_valid_q = 1.
6. Exhaustive sweep of all 16 en_in values, plus IN_W=5 and IN_W=8 builds.
   - Compare against a reference model: en_out = highest set index, en_valid = |en_in.
   - IN_W=5 check: 10000 -> en_out = 100 (OUT_W = 3).
